// File: rtl/data_ram_write_arbiter.sv
// Write-port arbiter for the shared data RAM. Three requesters are served in round-robin order.
// A granted requester can hold a burst lock on the port. The winning write goes into a
// registered stage that drives the RAM. Read-after-write hazards are flagged for both read ports.
module data_ram_write_arbiter #(
  parameter int unsigned DATA_ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_ROW_WIDTH     = 96,
  parameter int unsigned NUM_REQ            = 3
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [2:0]                    iReq,
  input  logic [2:0]                    iLock,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iAddr0,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iAddr1,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iAddr2,
  input  logic [DATA_ROW_WIDTH-1:0]     iData0,
  input  logic [DATA_ROW_WIDTH-1:0]     iData1,
  input  logic [DATA_ROW_WIDTH-1:0]     iData2,
  output logic [2:0]                    oAck,
  output logic                          oRamWriteEnable,
  output logic [DATA_ADDRESS_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_ROW_WIDTH-1:0]     oRamDataIn,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iReadAddress0,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iReadAddress1,
  output logic                          oHazard0,
  output logic                          oHazard1,
  output logic                          oLocked,
  output logic [1:0]                    oOwner
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    ptr_q, ptr_d;
  logic [1:0]                    owner_q, owner_d;
  logic                          we_q;
  logic [DATA_ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_ROW_WIDTH-1:0]     data_q;

  logic                          transfer;
  logic [1:0]                    win_idx;
  logic [DATA_ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_ROW_WIDTH-1:0]     win_data;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot3 = 3'b001;
      2'd1:    onehot3 = 3'b010;
      2'd2:    onehot3 = 3'b100;
      default: onehot3 = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] idx);
    inc3 = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Grant: owner only while locked, otherwise first requester searching from the pointer.
  always_comb begin
    logic [1:0] idx;
    oAck = 3'b000;
    idx  = ptr_q;
    if (Reset) begin
      if (state_q == StLocked) begin
        oAck = iReq & onehot3(owner_q);
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (oAck == 3'b000) begin
            oAck = iReq & onehot3(idx);
          end
          idx = inc3(idx);
        end
      end
    end
  end

  // Decode the one-hot grant into the winner's index, address and data.
  always_comb begin
    transfer = |(iReq & oAck);
    win_idx  = 2'd0;
    win_addr = iAddr0;
    win_data = iData0;
    case (oAck)
      3'b010: begin
        win_idx  = 2'd1;
        win_addr = iAddr1;
        win_data = iData1;
      end
      3'b100: begin
        win_idx  = 2'd2;
        win_addr = iAddr2;
        win_data = iData2;
      end
      default: ;
    endcase
  end

  // Lock FSM and round-robin pointer next-state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          ptr_d = inc3(win_idx);
          if (|(iLock & oAck)) begin
            state_d = StLocked;
            owner_d = win_idx;
          end
        end
      end
      StLocked: begin
        // Pointer stays frozen until the owner releases; release may coincide with a final write.
        if (!(|(iLock & onehot3(owner_q)))) begin
          state_d = StIdle;
          owner_d = 2'd3;
          ptr_d   = inc3(owner_q);
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = 2'd3;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      owner_q <= 2'd3;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Registered write stage: capture the winner; address and data hold when idle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= transfer;
      if (transfer) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  end

  // Outputs; hazards flag a read that would return pre-write data on the current write edge.
  always_comb begin
    oRamWriteEnable  = we_q;
    oRamWriteAddress = addr_q;
    oRamDataIn       = data_q;
    oLocked          = (state_q == StLocked);
    oOwner           = owner_q;
    oHazard0         = we_q & (iReadAddress0 == addr_q);
    oHazard1         = we_q & (iReadAddress1 == addr_q);
  end

endmodule

// File: tb/tb_data_ram_write_arbiter.sv
// Directed self-checking bench for data_ram_write_arbiter.
module tb_data_ram_write_arbiter;

  logic        Clock;
  logic        Reset;
  logic [2:0]  iReq, iLock, oAck;
  logic [7:0]  iAddr0, iAddr1, iAddr2, iReadAddress0, iReadAddress1, oRamWriteAddress;
  logic [95:0] iData0, iData1, iData2, oRamDataIn;
  logic        oRamWriteEnable, oHazard0, oHazard1, oLocked;
  logic [1:0]  oOwner;

  int errors = 0;
  int checks = 0;

  data_ram_write_arbiter dut (
    .Clock(Clock), .Reset(Reset), .iReq(iReq), .iLock(iLock),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iAddr2(iAddr2),
    .iData0(iData0), .iData1(iData1), .iData2(iData2),
    .oAck(oAck), .oRamWriteEnable(oRamWriteEnable), .oRamWriteAddress(oRamWriteAddress),
    .oRamDataIn(oRamDataIn), .iReadAddress0(iReadAddress0), .iReadAddress1(iReadAddress1),
    .oHazard0(oHazard0), .oHazard1(oHazard1), .oLocked(oLocked), .oOwner(oOwner)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    iReq  = 3'b111;
    tick();
    tick();
    checks++; if (oAck !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", oAck); end
    checks++; if (oRamWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", oRamWriteEnable); end
    checks++; if (oLocked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", oLocked); end
    checks++; if (oOwner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d expected 3", oOwner); end
    checks++; if (oRamWriteAddress !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", oRamWriteAddress); end
    Reset = 1'b1;
    #1;
    checks++; if (oAck !== 3'b001) begin errors++; $display("FAIL release_ack: got %b expected 001", oAck); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ack;
    logic [7:0] exp_addr;
    iReq = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ack  = 3'b001 << (k % 3);
      exp_addr = 8'h10 + 8'(k % 3);
      checks++; if (oAck !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, oAck, exp_ack); end
      tick();
      checks++; if (oRamWriteEnable !== 1'b1 || oRamWriteAddress !== exp_addr) begin
        errors++; $display("FAIL rr_write[%0d]: got we=%b addr=%h expected we=1 addr=%h", k, oRamWriteEnable, oRamWriteAddress, exp_addr);
      end
    end
    checks++; if (oRamDataIn !== 96'hC2) begin errors++; $display("FAIL rr_data: got %h expected c2", oRamDataIn); end
    iReq = 3'b000;
    #1;
    checks++; if (oAck !== 3'b000) begin errors++; $display("FAIL idle_ack: got %b expected 000", oAck); end
    tick();
    checks++; if (oRamWriteEnable !== 1'b0) begin errors++; $display("FAIL idle_we: got %b expected 0", oRamWriteEnable); end
    checks++; if (oRamWriteAddress !== 8'h12) begin errors++; $display("FAIL idle_hold: got %h expected 12", oRamWriteAddress); end
  endtask

  task automatic test_hazard();
    iReq = 3'b010; iAddr1 = 8'h05; iData1 = 96'h123;
    iReadAddress0 = 8'h00; iReadAddress1 = 8'h06;
    #1;
    checks++; if (oAck !== 3'b010) begin errors++; $display("FAIL hz_ack: got %b expected 010", oAck); end
    tick();
    iReq = 3'b000; iReadAddress0 = 8'h05;
    #1;
    checks++; if (oHazard0 !== 1'b1) begin errors++; $display("FAIL hz0_set: got %b expected 1", oHazard0); end
    checks++; if (oHazard1 !== 1'b0) begin errors++; $display("FAIL hz1_clr: got %b expected 0", oHazard1); end
    checks++; if (oRamDataIn !== 96'h123 || oRamWriteAddress !== 8'h05) begin
      errors++; $display("FAIL hz_write: got addr=%h data=%h expected addr=05 data=123", oRamWriteAddress, oRamDataIn);
    end
    tick();
    checks++; if (oHazard0 !== 1'b0) begin errors++; $display("FAIL hz0_drop: got %b expected 0", oHazard0); end
  endtask

  task automatic test_lock();
    // Pointer sits at 2 here; requester 0 alone wins and locks.
    iReq = 3'b001; iLock = 3'b001; iAddr0 = 8'h30;
    #1;
    checks++; if (oAck !== 3'b001) begin errors++; $display("FAIL lock_first_ack: got %b expected 001", oAck); end
    tick();
    checks++; if (oLocked !== 1'b1 || oOwner !== 2'd0) begin
      errors++; $display("FAIL lock_enter: got locked=%b owner=%0d expected locked=1 owner=0", oLocked, oOwner);
    end
    for (int t = 2; t <= 4; t++) begin
      iReq   = 3'b101;
      iLock  = (t == 4) ? 3'b000 : 3'b001;
      iAddr0 = 8'h30 + 8'(t);
      #1;
      checks++; if (oAck !== 3'b001) begin errors++; $display("FAIL lock_ack[%0d]: got %b expected 001", t, oAck); end
      tick();
      checks++; if (oLocked !== (t < 4) || oOwner !== ((t < 4) ? 2'd0 : 2'd3)) begin
        errors++; $display("FAIL lock_state[%0d]: got locked=%b owner=%0d", t, oLocked, oOwner);
      end
      checks++; if (oRamWriteAddress !== 8'h30 + 8'(t)) begin errors++; $display("FAIL lock_addr[%0d]: got %h", t, oRamWriteAddress); end
    end
    iReq = 3'b110; iLock = 3'b000;
    #1;
    checks++; if (oAck !== 3'b010) begin errors++; $display("FAIL unlock_ack1: got %b expected 010", oAck); end
    iReq = 3'b100;
    #1;
    checks++; if (oAck !== 3'b100) begin errors++; $display("FAIL unlock_ack2: got %b expected 100", oAck); end
    iReq = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    iReq = 3'b010; iLock = 3'b010; iAddr1 = 8'h44;
    #1;
    checks++; if (oAck !== 3'b010) begin errors++; $display("FAIL mid_ack: got %b expected 010", oAck); end
    tick();
    checks++; if (oLocked !== 1'b1 || oOwner !== 2'd1 || oRamWriteEnable !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got locked=%b owner=%0d we=%b expected 1/1/1", oLocked, oOwner, oRamWriteEnable);
    end
    Reset = 1'b0;
    #1;
    checks++; if (oAck !== 3'b000) begin errors++; $display("FAIL mid_rst_ack: got %b expected 000", oAck); end
    tick();
    checks++; if (oRamWriteEnable !== 1'b0 || oLocked !== 1'b0 || oOwner !== 2'd3) begin
      errors++; $display("FAIL mid_post: got we=%b locked=%b owner=%0d expected 0/0/3", oRamWriteEnable, oLocked, oOwner);
    end
    Reset = 1'b1; iReq = 3'b000; iLock = 3'b000;
    tick();
  endtask

  task automatic test_idle_zero();
    iReq = 3'b100; iAddr2 = 8'h52;
    #1;
    checks++; if (oAck !== 3'b100) begin errors++; $display("FAIL z_ack2: got %b expected 100", oAck); end
    tick();
    iReq = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (oAck !== 3'b000) begin errors++; $display("FAIL z_ack[%0d]: got %b expected 000", c, oAck); end
      tick();
      checks++; if (oRamWriteEnable !== 1'b0) begin errors++; $display("FAIL z_we[%0d]: got %b expected 0", c, oRamWriteEnable); end
    end
    iReq = 3'b011;
    #1;
    checks++; if (oAck !== 3'b001) begin errors++; $display("FAIL z_resume: got %b expected 001", oAck); end
  endtask

  task automatic test_back_to_back();
    iReq = 3'b001; iAddr0 = 8'h20;
    #1;
    tick();
    checks++; if (oRamWriteEnable !== 1'b1 || oRamWriteAddress !== 8'h20) begin
      errors++; $display("FAIL b2b_first: got we=%b addr=%h expected 1/20", oRamWriteEnable, oRamWriteAddress);
    end
    iAddr0 = 8'h21;
    #1;
    checks++; if (oAck !== 3'b001) begin errors++; $display("FAIL b2b_ack: got %b expected 001", oAck); end
    tick();
    checks++; if (oRamWriteEnable !== 1'b1 || oRamWriteAddress !== 8'h21) begin
      errors++; $display("FAIL b2b_second: got we=%b addr=%h expected 1/21", oRamWriteEnable, oRamWriteAddress);
    end
    iReq = 3'b000;
    tick();
  endtask

  initial begin
    Reset = 1'b0; iReq = 3'b000; iLock = 3'b000;
    iAddr0 = 8'h10; iAddr1 = 8'h11; iAddr2 = 8'h12;
    iData0 = 96'hA0; iData1 = 96'hB1; iData2 = 96'hC2;
    iReadAddress0 = 8'h00; iReadAddress1 = 8'h00;
    #2;
    test_reset();
    test_round_robin();
    test_hazard();
    test_lock();
    test_reset_mid();
    test_idle_zero();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
